// File: rtl/alu_pkg.sv
// Shared opcode encodings, NZCV flag bit positions and FSM states for alu_pipe.
package alu_pkg;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_ADC = 5'b00011;
    localparam logic [4:0] OP_SBC = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_ORR = 5'b00110;
    localparam logic [4:0] OP_EOR = 5'b00111;
    localparam logic [4:0] OP_MOV = 5'b01000;
    localparam logic [4:0] OP_MVN = 5'b01001;
    localparam logic [4:0] OP_LSL = 5'b01010;
    localparam logic [4:0] OP_LSR = 5'b01011;
    localparam logic [4:0] OP_ASR = 5'b01100;
    localparam logic [4:0] OP_CMP = 5'b10000;
    localparam logic [4:0] OP_MUL = 5'b10001;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per step.
// start captures operands; product is the accumulator after the current step, last marks the final step.
module alu_mul_iter #(
    parameter int REG_WIDTH = 16,
    parameter int MUL_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    output logic                 last,
    output logic [REG_WIDTH-1:0] product
);

    localparam int STEPS = REG_WIDTH / MUL_BITS;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    logic [REG_WIDTH-1:0] mcand;
    logic [REG_WIDTH-1:0] mplier;
    logic [REG_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;

    // Only the low REG_WIDTH bits are kept, so the multiplicand shifts out of range harmlessly.
    always_comb begin
        product = acc;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (mplier[j]) begin
                product = product + (mcand << j);
            end
        end
    end

    assign last = step && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with NZCV flag register, barrel shifts and an iterative multiplier.
// Single-cycle ops return one cycle after accept; MUL holds ready low for REG_WIDTH/MUL_BITS cycles.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 16,
    parameter int MUL_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_1_alu_valid,
    output logic                 o_1_alu_ready,
    input  logic [4:0]           i_5_alu_opcode,
    input  logic [REG_WIDTH-1:0] i_R_alu_in1,
    input  logic [REG_WIDTH-1:0] i_R_alu_in2,
    output logic [REG_WIDTH-1:0] or_R_alu_out,
    output logic                 or_1_alu_valid,
    output logic [3:0]           or_4_alu_flags,
    output logic                 or_1_alu_zero,
    output logic                 or_1_alu_illegal
);

    localparam int W = REG_WIDTH;

    state_t         state;
    logic           accept;
    logic           mul_last;
    logic [W-1:0]   mul_prod;

    logic [W-1:0]   op_b;
    logic           cin;
    logic [W:0]     sum;
    logic           ovf;
    logic [7:0]     sh;
    logic [W:0]     lsl_ext;
    logic [W:0]     lsr_ext;
    logic [W:0]     asr_ext;
    logic [W-1:0]   res;
    logic [3:0]     nflags;
    logic           upd_nz;
    logic           wr_out;
    logic           vld;
    logic           ill;

    assign o_1_alu_ready = (state == IDLE);
    assign accept        = i_1_alu_valid && o_1_alu_ready;
    assign or_1_alu_zero = or_4_alu_flags[FLG_Z];

    alu_mul_iter #(
        .REG_WIDTH (W),
        .MUL_BITS  (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && (i_5_alu_opcode == OP_MUL)),
        .step    (state == MUL_RUN),
        .a       (i_R_alu_in1),
        .b       (i_R_alu_in2),
        .last    (mul_last),
        .product (mul_prod)
    );

    always_comb begin
        op_b = i_R_alu_in2;
        cin  = 1'b0;
        case (i_5_alu_opcode)
            OP_SUB, OP_CMP: begin op_b = ~i_R_alu_in2; cin = 1'b1; end
            OP_SBC:         begin op_b = ~i_R_alu_in2; cin = or_4_alu_flags[FLG_C]; end
            OP_ADC:         cin = or_4_alu_flags[FLG_C];
            default:        ;
        endcase
        sum = {1'b0, i_R_alu_in1} + {1'b0, op_b} + {{W{1'b0}}, cin};
        ovf = (i_R_alu_in1[W-1] == op_b[W-1]) && (sum[W-1] != i_R_alu_in1[W-1]);

        // The extra bit in each extended shift catches the last bit shifted out.
        sh      = i_R_alu_in2[7:0];
        lsl_ext = {1'b0, i_R_alu_in1} << sh;
        lsr_ext = {i_R_alu_in1, 1'b0} >> sh;
        asr_ext = $signed({i_R_alu_in1, 1'b0}) >>> sh;

        res    = '0;
        nflags = or_4_alu_flags;
        upd_nz = 1'b0;
        wr_out = 1'b0;
        vld    = 1'b0;
        ill    = 1'b0;
        case (i_5_alu_opcode)
            OP_NOP, OP_MUL: ;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
                res           = sum[W-1:0];
                nflags[FLG_C] = sum[W];
                nflags[FLG_V] = ovf;
                upd_nz        = 1'b1;
                wr_out        = (i_5_alu_opcode != OP_CMP);
                vld           = 1'b1;
            end
            OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_MVN: begin
                case (i_5_alu_opcode)
                    OP_AND:  res = i_R_alu_in1 & i_R_alu_in2;
                    OP_ORR:  res = i_R_alu_in1 | i_R_alu_in2;
                    OP_EOR:  res = i_R_alu_in1 ^ i_R_alu_in2;
                    OP_MOV:  res = i_R_alu_in2;
                    default: res = ~i_R_alu_in2;
                endcase
                upd_nz = 1'b1;
                wr_out = 1'b1;
                vld    = 1'b1;
            end
            OP_LSL, OP_LSR, OP_ASR: begin
                if (sh == 8'd0) begin
                    res = i_R_alu_in1;
                end else if (i_5_alu_opcode == OP_LSL) begin
                    res           = lsl_ext[W-1:0];
                    nflags[FLG_C] = lsl_ext[W];
                end else if (i_5_alu_opcode == OP_LSR) begin
                    res           = lsr_ext[W:1];
                    nflags[FLG_C] = lsr_ext[0];
                end else begin
                    res           = asr_ext[W:1];
                    nflags[FLG_C] = asr_ext[0];
                end
                upd_nz = 1'b1;
                wr_out = 1'b1;
                vld    = 1'b1;
            end
            default: begin
                wr_out = 1'b1;
                vld    = 1'b1;
                ill    = 1'b1;
            end
        endcase
        if (upd_nz) begin
            nflags[FLG_N] = res[W-1];
            nflags[FLG_Z] = (res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            or_R_alu_out     <= '0;
            or_4_alu_flags   <= '0;
            or_1_alu_valid   <= 1'b0;
            or_1_alu_illegal <= 1'b0;
        end else begin
            or_1_alu_valid   <= 1'b0;
            or_1_alu_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (i_5_alu_opcode == OP_MUL) begin
                            state <= MUL_RUN;
                        end else begin
                            if (wr_out) or_R_alu_out <= res;
                            or_4_alu_flags   <= nflags;
                            or_1_alu_valid   <= vld;
                            or_1_alu_illegal <= ill;
                        end
                    end
                end
                MUL_RUN: begin
                    if (mul_last) begin
                        or_R_alu_out          <= mul_prod;
                        or_4_alu_flags[FLG_N] <= mul_prod[W-1];
                        or_4_alu_flags[FLG_Z] <= (mul_prod == '0);
                        or_1_alu_valid        <= 1'b1;
                        state                 <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (REG_WIDTH=16) with a MUL_BITS=1 and a MUL_BITS=4 instance.
module tb_alu_pipe;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_ADC = 5'b00011;
    localparam logic [4:0] OP_LSL = 5'b01010;
    localparam logic [4:0] OP_LSR = 5'b01011;
    localparam logic [4:0] OP_ASR = 5'b01100;
    localparam logic [4:0] OP_CMP = 5'b10000;
    localparam logic [4:0] OP_MUL = 5'b10001;
    localparam logic [4:0] OP_BAD = 5'b11111;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, valid4;
    logic [4:0]  opcode;
    logic [15:0] in1, in2;

    logic        rdy, out_vld, zero, illegal;
    logic [15:0] out;
    logic [3:0]  flags;
    logic        rdy4, out_vld4, zero4, illegal4;
    logic [15:0] out4;
    logic [3:0]  flags4;

    int checks = 0;
    int errors = 0;
    int busy;
    int pulses;

    always #5 clk = ~clk;

    alu_pipe #(.REG_WIDTH(16), .MUL_BITS(1)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .i_1_alu_valid    (valid),
        .o_1_alu_ready    (rdy),
        .i_5_alu_opcode   (opcode),
        .i_R_alu_in1      (in1),
        .i_R_alu_in2      (in2),
        .or_R_alu_out     (out),
        .or_1_alu_valid   (out_vld),
        .or_4_alu_flags   (flags),
        .or_1_alu_zero    (zero),
        .or_1_alu_illegal (illegal)
    );

    alu_pipe #(.REG_WIDTH(16), .MUL_BITS(4)) u_dut4 (
        .clk              (clk),
        .rst              (rst),
        .i_1_alu_valid    (valid4),
        .o_1_alu_ready    (rdy4),
        .i_5_alu_opcode   (opcode),
        .i_R_alu_in1      (in1),
        .i_R_alu_in2      (in2),
        .or_R_alu_out     (out4),
        .or_1_alu_valid   (out_vld4),
        .or_4_alu_flags   (flags4),
        .or_1_alu_zero    (zero4),
        .or_1_alu_illegal (illegal4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one request for a single edge; returns #1 after that edge.
    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input bit sel4);
        opcode = op;
        in1    = a;
        in2    = b;
        if (sel4) valid4 = 1'b1; else valid = 1'b1;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        valid4 = 1'b0;
    endtask

    task automatic wait_ready(input bit sel4, output int n);
        n = 0;
        while ((sel4 ? !rdy4 : !rdy) && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; valid4 = 1'b0;
        opcode = OP_NOP; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out",   out, 0);
        check("rst_flags", flags, 0);
        check("rst_valid", out_vld, 0);
        check("rst_ready", rdy, 1);
        check("rst_zero",  zero, 0);

        issue(OP_ADD, 16'h7FFF, 16'h0001, 0);
        check("add_ovf_out",   out, 16'h8000);
        check("add_ovf_flags", flags, 4'b1001);
        check("add_ovf_valid", out_vld, 1);
        issue(OP_SUB, 16'h0005, 16'h0005, 0);
        check("sub_eq_out",   out, 16'h0000);
        check("sub_eq_flags", flags, 4'b0110);
        check("sub_eq_zero",  zero, 1);

        issue(OP_ADD, 16'hFFFF, 16'h0001, 0);
        check("add_carry_flags", flags, 4'b0110);
        issue(OP_ADC, 16'h0001, 16'h0001, 0);
        check("adc_out",   out, 16'h0003);
        check("adc_flags", flags, 4'b0000);
        check("adc_valid", out_vld, 1);
        issue(OP_NOP, 16'h1111, 16'h2222, 0);
        check("nop_valid", out_vld, 0);
        check("nop_out",   out, 16'h0003);

        issue(OP_LSL, 16'h8001, 16'd1, 0);
        check("lsl1_out",   out, 16'h0002);
        check("lsl1_flags", flags, 4'b0010);
        issue(OP_LSR, 16'h8001, 16'd16, 0);
        check("lsr16_out",   out, 16'h0000);
        check("lsr16_flags", flags, 4'b0110);
        issue(OP_ASR, 16'h8000, 16'd20, 0);
        check("asr20_out",   out, 16'hFFFF);
        check("asr20_flags", flags, 4'b1010);
        issue(OP_LSL, 16'h1234, 16'd0, 0);
        check("lsl0_out",   out, 16'h1234);
        check("lsl0_flags", flags, 4'b0010);
        issue(OP_LSL, 16'h1234, 16'd20, 0);
        check("lsl20_out",   out, 16'h0000);
        check("lsl20_flags", flags, 4'b0100);

        issue(OP_ADD, 16'h7FFF, 16'h0001, 0);
        issue(OP_MUL, 16'h0123, 16'h0010, 0);
        check("mul_ready_low", rdy, 0);
        opcode = OP_ADD; in1 = 16'h0001; in2 = 16'h0001; valid = 1'b1;
        wait_ready(0, busy);
        valid = 1'b0;
        check("mul_busy_cycles", busy, 16);
        check("mul_valid", out_vld, 1);
        check("mul_out",   out, 16'h1230);
        check("mul_flags", flags, 4'b0001);
        @(posedge clk);
        #1;
        check("mul_busy_req_ignored_vld", out_vld, 0);
        check("mul_busy_req_ignored_out", out, 16'h1230);

        issue(OP_MUL, 16'hFFFF, 16'h0003, 1);
        wait_ready(1, busy);
        check("mul4_busy_cycles", busy, 4);
        check("mul4_valid", out_vld4, 1);
        check("mul4_out",   out4, 16'hFFFD);
        check("mul4_flags", flags4, 4'b1000);
        @(posedge clk);
        #1;
        check("mul4_valid_pulse", out_vld4, 0);

        issue(OP_MUL, 16'h0123, 16'h0010, 0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out",   out, 0);
        check("abort_flags", flags, 0);
        check("abort_ready", rdy, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_vld) pulses++;
            @(posedge clk);
            #1;
        end
        check("abort_no_valid", pulses, 0);
        issue(OP_ADD, 16'h0002, 16'h0003, 0);
        check("post_abort_out",   out, 16'h0005);
        check("post_abort_valid", out_vld, 1);

        issue(OP_ADD, 16'h7FFF, 16'h0001, 0);
        issue(OP_BAD, 16'h1234, 16'h5678, 0);
        check("illegal_out",   out, 16'h0000);
        check("illegal_pulse", illegal, 1);
        check("illegal_valid", out_vld, 1);
        check("illegal_flags", flags, 4'b1001);
        issue(OP_ADD, 16'h0001, 16'h0001, 0);
        check("illegal_cleared", illegal, 0);
        issue(OP_CMP, 16'h0003, 16'h0005, 0);
        check("cmp_flags", flags, 4'b1000);
        check("cmp_out",   out, 16'h0002);
        check("cmp_valid", out_vld, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the single-cycle datapath ALU, for the next core revision.
- Adds a valid/ready handshake, a registered NZCV flag register with carry-in ops, barrel shifts, and an iterative multiply that takes several cycles.
- Sits between the decode/operand-fetch stage and writeback.
- Keeps the legacy zero output so existing branch logic still works.

Parameters:
- REG_WIDTH, 16: datapath width in bits. Must be ≥8 and a power of 2.
- MUL_BITS, 1: multiplier bits retired per cycle. Must be a power of 2 that divides REG_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_1_alu_valid  in  1  operation request.
- o_1_alu_ready  out  1  block can accept; high only in IDLE (combinational from state).
- i_5_alu_opcode  in  5  operation select.
- i_R_alu_in1  in  REG_WIDTH  operand A (shift source, multiplicand).
- i_R_alu_in2  in  REG_WIDTH  operand B (shift amount in [7:0], multiplier).
- or_R_alu_out  out  REG_WIDTH  result.
- or_1_alu_valid  out  1  one-cycle pulse when or_R_alu_out is new.
- or_4_alu_flags  out  4  registered flags {N,Z,C,V}.
- or_1_alu_zero  out  1  copy of the Z flag.
- or_1_alu_illegal  out  1  one-cycle pulse when an undefined opcode is accepted.

Behaviour:
- **Reset.** All outputs go to 0 and the state goes to IDLE. A reset during a multiply aborts it: no valid pulse, flags cleared.
- **Accept.** A request is accepted when i_1_alu_valid and o_1_alu_ready are both high at a clk edge. Inputs are ignored while ready is low.
- **Single-cycle ops.** Operands are sampled, and result and flags registered, at the accept edge. or_1_alu_valid is high in the next cycle. Back-to-back issue is allowed every cycle; a following ADC/SBC sees the flags written by the previous op.
- **Opcodes** (5-bit):
  - NOP 00000: no valid pulse, nothing changes.
  - ADD 00001: A+B.
  - SUB 00010: A-B.
  - ADC 00011: A+B+C.
  - SBC 00100: A-B-!C.
  - AND 00101, ORR 00110, EOR 00111.
  - MOV 01000: B.
  - MVN 01001: ~B.
  - LSL 01010, LSR 01011, ASR 01100.
  - CMP 10000: computes A-B, updates flags, or_R_alu_out unchanged, valid still pulses.
  - MUL 10001.
- **Flags.**
  - N = result MSB; Z = (result == 0).
  - Add/sub ops: C = carry out (for subtracts, C = no-borrow); V = signed overflow.
  - Logical, MOV, MVN: N and Z update; C and V unchanged.
  - Shifts: N and Z update; C = last bit shifted out; V unchanged.
  - MUL: N and Z update; C and V unchanged.
- **Shifts.** Shift amount s = B[7:0].
  - s=0: result = A, C unchanged.
  - s=REG_WIDTH: LSL gives C=A[0], LSR gives C=A[W-1], result 0.
  - s>REG_WIDTH: LSL/LSR give result 0, C=0.
  - ASR with s≥REG_WIDTH: result is all copies of A[W-1], C=A[W-1].
- **MUL.**
  - The accept edge captures the operands, moves to MUL_RUN, and clears the step counter.
  - Each following edge adds MUL_BITS partial products; there are REG_WIDTH/MUL_BITS steps in total.
  - The final step writes the low REG_WIDTH bits of the product and the flags, and returns to IDLE.
  - Valid pulses in the next cycle; ready is high again in that same cycle.
  - Ready is low for exactly REG_WIDTH/MUL_BITS cycles.
- **Undefined opcodes.** or_R_alu_out is written 0, flags are unchanged, and or_1_alu_valid and or_1_alu_illegal both pulse.
- **States.**
  - IDLE -> MUL_RUN on an accepted MUL.
  - MUL_RUN -> IDLE when the counter reaches REG_WIDTH/MUL_BITS-1.
  - rst -> IDLE from any state.
- **Widths.** All arithmetic is modulo 2^REG_WIDTH. Carry is taken from a REG_WIDTH+1-bit sum.

Decomposition:
- Package alu_pkg holds the opcode localparams, flag bit indices (N=3, Z=2, C=1, V=0) and state encodings.
- Sub-module alu_mul_iter: iterative shift-add multiplier with start/done and a step counter, parametrised by REG_WIDTH and MUL_BITS.
- The top level holds the FSM, flag register, add/logic/shift datapath and output registers.

Test Plan (REG_WIDTH=16, MUL_BITS=1 unless stated):
1. ADD A=0x7FFF, B=0x0001 -> out 0x8000, flags N=1 Z=0 C=0 V=1, valid in the next cycle. Then SUB A=0x0005, B=0x0005 -> out 0x0000, Z=1, C=1, or_1_alu_zero=1.
2. ADD 0xFFFF+0x0001 sets C=1; next cycle ADC 0x0001+0x0001 -> 0x0003. Checks back-to-back issue and carry forwarding.
3. LSL A=0x8001 s=1 -> 0x0002, C=1. LSR s=16 -> 0x0000, C=A[15]. ASR A=0x8000 s=20 -> 0xFFFF, C=1. LSL s=0 -> A, C unchanged.
4. MUL 0x0123×0x0010 -> 0x1230. Ready is low for 16 cycles and valid arrives 17 cycles after the request cycle; requests made while busy are ignored. Repeat with MUL_BITS=4 -> 4 busy cycles.
5. Assert rst at MUL step 7 -> no valid pulse, flags and out 0, ready high the cycle after reset. A following ADD executes normally.
6. Opcode 11111 -> or_R_alu_out 0, illegal and valid pulse, flags unchanged. CMP 3 vs 5 -> N=1, C=0, or_R_alu_out holds its previous value.
